// File: rtl/qr_pkg.sv
// Shared constants and FSM state type for the 3x3 QR recomposition datapath.
package qr_pkg;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned FRAC_BITS  = 8;
  localparam int unsigned N          = 3;
  localparam int unsigned Q_WORDS    = N * N;
  localparam int unsigned R_WORDS    = N * (N + 1) / 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_Q,
    LOAD_R,
    MAC,
    EMIT,
    DONE
  } state_t;
endpackage

// File: rtl/qr_mac.sv
// Signed multiply-accumulate with clear, plus floor-shift and saturation of the running sum.
module qr_mac #(
  parameter int unsigned DATA_WIDTH = qr_pkg::DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = qr_pkg::FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] sat_c
);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + 2;
  localparam int unsigned PAD_W  = ACC_W - DATA_WIDTH + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{PAD_W{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{PAD_W{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  base_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  shifted_c;

  // Full-precision product; clr restarts the sum with this cycle's term.
  assign prod_c    = PROD_W'(a) * PROD_W'(b);
  assign base_c    = clr ? '0 : acc;
  assign sum_c     = base_c + ACC_W'(prod_c);
  assign shifted_c = sum_c >>> FRAC_BITS;

  always_comb begin
    sat_c = shifted_c[DATA_WIDTH-1:0];
    if (shifted_c > SAT_HI) begin
      sat_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted_c < SAT_LO) begin
      sat_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_c;
    end
  end
endmodule

// File: rtl/qr_recompose.sv
// Streams in Q (row-major) and the upper triangle of R, then emits A = Q*R row-major.
module qr_recompose
  import qr_pkg::state_t, qr_pkg::IDLE, qr_pkg::LOAD_Q, qr_pkg::LOAD_R,
         qr_pkg::MAC, qr_pkg::EMIT, qr_pkg::DONE, qr_pkg::N,
         qr_pkg::Q_WORDS, qr_pkg::R_WORDS;
#(
  parameter int unsigned DATA_WIDTH = qr_pkg::DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = qr_pkg::FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  done
);
  state_t state;
  state_t next_state;

  logic [3:0] load_cnt;
  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] kk;

  logic signed [DATA_WIDTH-1:0] q_mem [Q_WORDS];
  logic signed [DATA_WIDTH-1:0] r_mem [R_WORDS];

  logic signed [DATA_WIDTH-1:0] q_op_c;
  logic signed [DATA_WIDTH-1:0] r_op_c;
  logic signed [DATA_WIDTH-1:0] sat_c;
  logic [2:0] r_idx_c;
  logic mac_en_c;
  logic mac_clr_c;
  logic last_k_c;
  logic last_col_c;
  logic last_elem_c;
  logic load_q_c;
  logic load_r_c;

  assign last_k_c    = (kk == 2'(N - 1));
  assign last_col_c  = (col == 2'(N - 1));
  assign last_elem_c = last_col_c && (row == 2'(N - 1));
  assign load_q_c    = (state == LOAD_Q) && in_valid;
  assign load_r_c    = (state == LOAD_R) && in_valid;

  // Packed upper-triangle offset of r(kk, col); below-diagonal terms read as zero.
  always_comb begin
    case (kk)
      2'd1:    r_idx_c = 3'(col) + 3'd2;
      2'd2:    r_idx_c = 3'(col) + 3'd3;
      default: r_idx_c = 3'(col);
    endcase
    q_op_c = q_mem[4'(row) * 4'(N) + 4'(kk)];
    r_op_c = '0;
    if (kk <= col) begin
      r_op_c = r_mem[r_idx_c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mac_en_c   = 1'b0;
    mac_clr_c  = 1'b0;
    case (state)
      IDLE:   if (start) next_state = LOAD_Q;
      LOAD_Q: if (in_valid && load_cnt == 4'(Q_WORDS - 1)) next_state = LOAD_R;
      LOAD_R: if (in_valid && load_cnt == 4'(R_WORDS - 1)) next_state = MAC;
      MAC: begin
        mac_en_c  = 1'b1;
        mac_clr_c = (kk == 2'd0);
        if (last_k_c) next_state = EMIT;
      end
      EMIT:    next_state = last_elem_c ? DONE : MAC;
      default: next_state = IDLE;
    endcase
  end

  // Operand storage is write-only during loads and needs no reset.
  always_ff @(posedge clk) begin
    if (load_q_c) q_mem[load_cnt] <= in_data;
    if (load_r_c) r_mem[load_cnt[2:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt  <= '0;
      row       <= '0;
      col       <= '0;
      kk        <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
    end else begin
      busy      <= (next_state != IDLE);
      out_valid <= (next_state == EMIT);
      done      <= (next_state == DONE);
      if (state == MAC && last_k_c) out_data <= sat_c;
      case (state)
        LOAD_Q: if (in_valid) load_cnt <= (load_cnt == 4'(Q_WORDS - 1)) ? '0 : load_cnt + 4'd1;
        LOAD_R: if (in_valid) load_cnt <= (load_cnt == 4'(R_WORDS - 1)) ? '0 : load_cnt + 4'd1;
        MAC:    kk <= last_k_c ? '0 : kk + 2'd1;
        EMIT: begin
          if (last_col_c) begin
            col <= '0;
            row <= last_elem_c ? '0 : row + 2'd1;
          end else begin
            col <= col + 2'd1;
          end
        end
        default: begin
          load_cnt <= '0;
          row      <= '0;
          col      <= '0;
          kk       <= '0;
        end
      endcase
    end
  end

  qr_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .en   (mac_en_c),
    .clr  (mac_clr_c),
    .a    (q_op_c),
    .b    (r_op_c),
    .sat_c(sat_c)
  );
endmodule

// File: tb/tb_qr_recompose.sv
// Directed bench for qr_recompose: hand-computed A = Q*R frames, timing, saturation and abort cases.
module tb_qr_recompose;
  typedef logic [15:0] vq_t [9];
  typedef logic [15:0] vr_t [6];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic        out_valid;
  logic [15:0] out_data;
  logic        done;

  int tests = 0;
  int fails = 0;

  qr_recompose dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .out_valid(out_valid),
    .out_data (out_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a frame and streams Q then R; returns one cycle after r33 is accepted.
  task automatic load_frame(input vq_t qv, input vr_t rv, input int gap, input bit start_in_r);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = qv[i];
      step();
      in_valid = 1'b0;
      repeat (gap) step();
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = rv[i];
      start    = start_in_r && (i == 2);
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      if (i < 5) repeat (gap) step();
    end
  endtask

  // Gathers the nine outputs, checking values, cadence, done pulse and hold behaviour.
  task automatic collect(input string name, input vq_t exp, input bit noise);
    int cyc = 1;
    int n = 0;
    int prev = -100;
    int done_cyc = -1;
    logic [15:0] last = '0;
    in_valid = noise;
    in_data  = 16'hdead;
    for (int t = 0; t < 60 && done_cyc < 0; t++) begin
      start = 1'b0;
      if (out_valid) begin
        if (n < 9) check($sformatf("%s a%0d", name, n), 32'(out_data), 32'(exp[n]));
        if (n == 0) check($sformatf("%s first latency", name), 32'(cyc), 32'd4);
        else        check($sformatf("%s spacing", name), 32'(cyc - prev), 32'd4);
        prev = cyc;
        last = out_data;
        n++;
        start = noise && (n == 3);
      end
      if (done) begin
        done_cyc = cyc;
        check($sformatf("%s busy in done", name), 32'(busy), 32'd1);
        check($sformatf("%s data hold", name), 32'(out_data), 32'(last));
      end
      step();
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check($sformatf("%s count", name), 32'(n), 32'd9);
    check($sformatf("%s done timing", name), 32'(done_cyc), 32'(prev + 1));
    check($sformatf("%s idle after", name), 32'({busy, out_valid, done}), 32'd0);
  endtask

  initial begin
    vq_t q_id, q_neg, q_half, q_ones, q_max, q_min;
    vr_t r_base, r_floor, r_top;
    vq_t a_id, a_neg, a_floor, a_ones, a_max, a_min;

    q_id    = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
    q_neg   = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
    q_half  = '{16'hFF80, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
    q_ones  = '{9{16'h0100}};
    q_max   = '{9{16'h7FFF}};
    q_min   = '{9{16'h8000}};
    r_base  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
    r_floor = '{16'h0001, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
    r_top   = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};

    a_id    = '{16'h0100, 16'h0200, 16'h0300, 16'h0000, 16'h0400, 16'h0500, 16'h0000, 16'h0000, 16'h0600};
    a_neg   = '{16'hFF00, 16'hFE00, 16'hFD00, 16'h0000, 16'h0400, 16'h0500, 16'h0000, 16'h0000, 16'h0600};
    a_floor = '{16'hFFFF, 16'hFF00, 16'hFE80, 16'h0000, 16'h0400, 16'h0500, 16'h0000, 16'h0000, 16'h0600};
    a_ones  = '{16'h0100, 16'h0600, 16'h0E00, 16'h0100, 16'h0600, 16'h0E00, 16'h0100, 16'h0600, 16'h0E00};
    a_max   = '{9{16'h7FFF}};
    a_min   = '{9{16'h8000}};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) step();
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);

    load_frame(q_id, r_base, 0, 1'b0);
    collect("identity", a_id, 1'b0);

    load_frame(q_neg, r_base, 0, 1'b0);
    collect("neg_q11", a_neg, 1'b0);

    load_frame(q_half, r_floor, 0, 1'b0);
    collect("floor", a_floor, 1'b0);

    load_frame(q_ones, r_base, 0, 1'b0);
    collect("accum", a_ones, 1'b0);

    load_frame(q_max, r_top, 0, 1'b0);
    collect("sat_pos", a_max, 1'b0);

    load_frame(q_min, r_top, 0, 1'b0);
    collect("sat_neg", a_min, 1'b0);

    load_frame(q_id, r_base, 3, 1'b0);
    collect("gapped", a_id, 1'b0);

    load_frame(q_id, r_base, 0, 1'b1);
    collect("start_ignored", a_id, 1'b1);

    // Abort in the middle of the a22 MAC window, then run a clean frame.
    load_frame(q_id, r_base, 0, 1'b0);
    repeat (17) step();
    check("abort busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort out_data", 32'(out_data), 32'd0);
    step();
    check("abort stays idle", 32'(busy), 32'd0);

    load_frame(q_id, r_base, 0, 1'b0);
    collect("post_abort", a_id, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qr_recompose.md
QR_RECOMPOSE -- requirements
Module: qr_recompose

Interface
REQ-001 Parameter DATA_WIDTH, default 16, meaning: signed fixed-point word width of every matrix element.
REQ-002 Parameter FRAC_BITS, default 8, meaning: fractional bits (Q8.8), so 1.0 = 0x0100.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  begins a new frame when sampled high in IDLE.
REQ-006 Port in_valid  input  1  in_data holds a valid element this cycle.
REQ-007 Port in_data  input  DATA_WIDTH  streamed element: Q, then the R upper triangle.
REQ-008 Port busy  output  1  high in every state except IDLE.
REQ-009 Port out_valid  output  1  out_data holds one element of A = Q*R.
REQ-010 Port out_data  output  DATA_WIDTH  reconstructed element of A, row-major.
REQ-011 Port done  output  1  one-cycle pulse after the last A element.

Function
REQ-012 Matrix size fixed at 3x3; block computes A = Q*R, the inverse direction of the team's QR decomposer.
REQ-013 FSM states: IDLE, LOAD_Q, LOAD_R, MAC, EMIT, DONE.
REQ-014 IDLE -> LOAD_Q on start; start and in_valid outside IDLE/LOAD states ignored; in_valid in the start cycle not captured.
REQ-015 LOAD_Q: capture 9 words on in_valid, row-major q11,q12,q13,q21..q33; in_valid low stalls with no state change; after the 9th word -> LOAD_R.
REQ-016 LOAD_R: capture 6 words on in_valid: r11,r12,r13,r22,r23,r33; below-diagonal R treated as 0; after the 6th word -> MAC.
REQ-017 MAC: for element a_ij, three cycles k=1,2,3 each adding q_ik*r_kj (r_kj=0 for k>j) to an accumulator cleared at element start.
REQ-018 Products are full 2*DATA_WIDTH signed; accumulator at least 2*DATA_WIDTH+2 bits; no intermediate truncation.
REQ-019 EMIT: out_data = accumulator arithmetically shifted right by FRAC_BITS (floor), saturated to [0x8000, 0x7FFF]; out_valid high for exactly this one cycle.
REQ-020 After EMIT: next element (j, then i increments) -> MAC; after a33 -> DONE.
REQ-021 First out_valid occurs in the 4th cycle after the cycle accepting r33; subsequent elements every 4 cycles; 36 cycles for the full output.
REQ-022 DONE: done=1 for one cycle, busy still 1; then IDLE unconditionally.
REQ-023 out_data holds its last emitted value while out_valid is low.
REQ-024 No backpressure: the consumer must accept every out_valid cycle.

Reset
REQ-025 reset high, in any state including mid-load or mid-compute, forces IDLE on the next edge, aborting the frame.
REQ-026 Reset values: busy=0, out_valid=0, done=0, out_data=0, accumulator=0, element/k counters=0; Q/R storage need not be cleared.

Structure
REQ-027 Shared package qr_pkg holds DATA_WIDTH, FRAC_BITS, matrix dimension N=3, and the FSM state enum type.
REQ-028 One sub-module qr_mac: signed multiply, accumulate with clear, shift-and-saturate output; the FSM, counters and storage stay in qr_recompose.

Verification
REQ-029 Q=identity (0x0100 on diagonal), R = 0x0100,0x0200,0x0300,0x0400,0x0500,0x0600 -> outputs 0x0100,0x0200,0x0300,0,0x0400,0x0500,0,0,0x0600; done one cycle after the last.
REQ-030 q11=0xFF00 (-1.0), rest of Q identity, R as in REQ-029 -> first row 0xFF00,0xFE00,0xFD00, remaining rows unchanged.
REQ-031 Q all 0x7FFF, r11=r12=r13=0x7FFF, rest 0 -> every element 0x7FFF (positive saturation); Q all 0x8000 same R -> 0x8000.
REQ-032 REQ-029 stimulus with in_valid low for 3 cycles between every word -> identical output values; first out_valid 4 cycles after r33 accepted.
REQ-033 reset asserted one cycle during MAC of a22 -> out_valid/done/busy low next cycle; a fresh REQ-029 frame then completes correctly.
REQ-034 start pulsed during LOAD_R and during EMIT -> ignored, no restart, output of the original frame unchanged.
